// File: rtl/lfsr_multi_poly_finder_if.sv
// Request/result bundle between the sweep decoder, the polynomial finder and
// the downstream position solver.
interface lfsr_multi_poly_finder_if #(
    parameter int WIDTH    = 17,
    parameter int TS_WIDTH = 24,
    parameter int ITER_W   = 17,
    parameter int IDX_W    = 4
);
    // Request: start is taken only in a cycle where ready=1.
    // Result: result_valid holds with all result fields stable until a cycle
    // with result_ack=1; ready returns the following cycle.
    logic                start;
    logic [TS_WIDTH-1:0] ts_first;
    logic [TS_WIDTH-1:0] ts_second;
    logic [WIDTH-1:0]    data_first;
    logic [WIDTH-1:0]    data_second;
    logic                ready;
    logic                result_valid;
    logic                result_ack;
    logic                result_found;
    logic [IDX_W-1:0]    result_index;
    logic [WIDTH-1:0]    polynomial;
    logic [ITER_W-1:0]   iteration_number;

    modport master (
        output start, ts_first, ts_second, data_first, data_second, result_ack,
        input  ready, result_valid, result_found, result_index, polynomial,
               iteration_number
    );

    modport slave (
        input  start, ts_first, ts_second, data_first, data_second, result_ack,
        output ready, result_valid, result_found, result_index, polynomial,
               iteration_number
    );
endinterface

// File: rtl/lfsr_multi_poly_finder.sv
// Steps NUM_POLY Galois LFSRs from the first decoded word and reports which
// polynomial reaches the second word inside a timestamp-derived step window.
module lfsr_multi_poly_finder #(
    parameter int WIDTH       = 17,
    parameter int NUM_POLY    = 2,
    parameter logic [NUM_POLY*WIDTH-1:0] POLYS = {17'h17e04, 17'h1d258},
    parameter int TS_WIDTH    = 24,
    parameter int TS_SHIFT    = 4,
    parameter int ITER_APPROX = 3,
    parameter int ITER_W      = 17,
    parameter int MAX_ITER    = 8191,
    parameter int IDX_W       = 4
) (
    input  logic                          clk_96MHz,
    input  logic                          reset,
    lfsr_multi_poly_finder_if.slave       bus,
    output logic [1:0]                    dbg_state_o
);
    localparam int EST_W = TS_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_ESTIMATE, S_SEARCH, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [TS_WIDTH-1:0] ts_first_q, ts_first_d, ts_second_q, ts_second_d;
    logic [WIDTH-1:0]    data_first_q, data_first_d, data_second_q, data_second_d;
    logic [ITER_W-1:0]   win_lo_q, win_lo_d, win_hi_q, win_hi_d, k_q, k_d;
    logic [WIDTH-1:0]    lfsr_q [NUM_POLY];
    logic [WIDTH-1:0]    lfsr_d [NUM_POLY];
    logic                found_q, found_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [WIDTH-1:0]    poly_q, poly_d;
    logic [ITER_W-1:0]   iter_q, iter_d;

    logic [TS_WIDTH-1:0] delta;
    logic [EST_W-1:0]    est, lo_wide, hi_wide, hi_clamp;
    logic                hit, in_win;
    logic [IDX_W-1:0]    hit_idx;
    logic [WIDTH-1:0]    hit_poly;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v,
                                                    input logic [WIDTH-1:0] p);
        return v[0] ? ((v >> 1) ^ p) : (v >> 1);
    endfunction

    // Modular subtraction keeps the delta exact across timestamp wrap.
    always_comb begin
        delta    = ts_second_q - ts_first_q;
        est      = EST_W'(delta >> TS_SHIFT);
        lo_wide  = (est >= EST_W'(ITER_APPROX)) ? est - EST_W'(ITER_APPROX) : '0;
        hi_wide  = est + EST_W'(ITER_APPROX);
        hi_clamp = (hi_wide > EST_W'(MAX_ITER)) ? EST_W'(MAX_ITER) : hi_wide;
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_poly = '0;
        for (int i = NUM_POLY - 1; i >= 0; i--) begin
            if (lfsr_q[i] == data_second_q) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_poly = POLYS[i*WIDTH +: WIDTH];
            end
        end
        in_win = (k_q >= win_lo_q) && (k_q <= win_hi_q);
    end

    always_comb begin
        state_d       = state_q;
        ts_first_d    = ts_first_q;
        ts_second_d   = ts_second_q;
        data_first_d  = data_first_q;
        data_second_d = data_second_q;
        win_lo_d      = win_lo_q;
        win_hi_d      = win_hi_q;
        k_d           = k_q;
        lfsr_d        = lfsr_q;
        found_d       = found_q;
        index_d       = index_q;
        poly_d        = poly_q;
        iter_d        = iter_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ts_first_d    = bus.ts_first;
                    ts_second_d   = bus.ts_second;
                    data_first_d  = bus.data_first;
                    data_second_d = bus.data_second;
                    state_d       = S_ESTIMATE;
                end
            end
            S_ESTIMATE: begin
                for (int i = 0; i < NUM_POLY; i++) lfsr_d[i] = data_first_q;
                k_d     = '0;
                state_d = S_SEARCH;
                // An empty window (lo=1, hi=0) makes SEARCH give up at k=0,
                // which keeps the abort path on the same latency as a k=0 hit.
                if (data_first_q == '0 || lo_wide > EST_W'(MAX_ITER)) begin
                    win_lo_d = ITER_W'(1);
                    win_hi_d = '0;
                end else begin
                    win_lo_d = ITER_W'(lo_wide);
                    win_hi_d = ITER_W'(hi_clamp);
                end
            end
            S_SEARCH: begin
                if (in_win && hit) begin
                    found_d = 1'b1;
                    index_d = hit_idx;
                    poly_d  = hit_poly;
                    iter_d  = k_q;
                    state_d = S_DONE;
                end else if (k_q == win_hi_q) begin
                    found_d = 1'b0;
                    index_d = '0;
                    poly_d  = '0;
                    iter_d  = k_q;
                    state_d = S_DONE;
                end else begin
                    for (int i = 0; i < NUM_POLY; i++)
                        lfsr_d[i] = lfsr_step(lfsr_q[i], POLYS[i*WIDTH +: WIDTH]);
                    k_d = k_q + ITER_W'(1);
                end
            end
            S_DONE: begin
                if (bus.result_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ts_first_q    <= '0;
            ts_second_q   <= '0;
            data_first_q  <= '0;
            data_second_q <= '0;
            win_lo_q      <= '0;
            win_hi_q      <= '0;
            k_q           <= '0;
            for (int i = 0; i < NUM_POLY; i++) lfsr_q[i] <= '0;
            found_q       <= 1'b0;
            index_q       <= '0;
            poly_q        <= '0;
            iter_q        <= '0;
        end else begin
            state_q       <= state_d;
            ts_first_q    <= ts_first_d;
            ts_second_q   <= ts_second_d;
            data_first_q  <= data_first_d;
            data_second_q <= data_second_d;
            win_lo_q      <= win_lo_d;
            win_hi_q      <= win_hi_d;
            k_q           <= k_d;
            for (int i = 0; i < NUM_POLY; i++) lfsr_q[i] <= lfsr_d[i];
            found_q       <= found_d;
            index_q       <= index_d;
            poly_q        <= poly_d;
            iter_q        <= iter_d;
        end
    end

    assign bus.ready            = (state_q == S_IDLE);
    assign bus.result_valid     = (state_q == S_DONE);
    assign bus.result_found     = found_q;
    assign bus.result_index     = index_q;
    assign bus.polynomial       = poly_q;
    assign bus.iteration_number = iter_q;
    assign dbg_state_o          = state_q;
endmodule
